mac_stream: RTL and testbench

Multi-lane, pipelined, streaming multiply-accumulate engine that generalises the scalar MAC into the dot-product datapath of the matrix unit. It accepts LANES independent signed operand pairs per beat over a valid/ready handshake and accumulates products until a beat marked last. It then presents one dot-product result per lane on a backpressured output register. It sits between the operand fetch/sequencer logic and the result writeback logic.

---
 rtl/mac_stream.sv | 174 +++++++++++++++++
 tb/tb_mac_stream.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_stream.sv
// mac_stream: multi-lane pipelined streaming multiply-accumulate engine.
// Each beat carries LANES signed operand pairs. Products are accumulated per
// lane until a beat marked last, then one dot product per lane is presented
// on a backpressured output register together with its term count.
//
// Optional feature macro: MAC_STREAM_SAT_EN
//   defined   -> lane results saturate to the signed OUT_W range
//   undefined -> lane results are the low OUT_W bits of the accumulator
//
// Pipeline: stage 1 (_p1) registers the products, stage 2 (_p2) holds the
// accumulators, and the output register follows stage 2.
module mac_stream #(
    parameter int DATA_W = 16,
    parameter int K_MAX  = 4,
    parameter int LANES  = 4,
    parameter int OUT_W  = 2 * DATA_W
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic                                      in_last,
    input  logic [LANES*DATA_W-1:0]                   a_in,
    input  logic [LANES*DATA_W-1:0]                   b_in,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [LANES*OUT_W-1:0]                    out_data,
    output logic [$clog2(K_MAX+1)-1:0]                out_count,
    output logic                                      term_err
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int ACC_W  = 2 * DATA_W + $clog2(K_MAX) + 1;
    localparam int CNT_W  = $clog2(K_MAX + 1);

`ifdef MAC_STREAM_SAT_EN
    // Saturation bounds of the signed OUT_W range, expressed at accumulator width.
    localparam logic signed [ACC_W-1:0] OUT_MIN =
        {{(ACC_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};
    localparam logic signed [ACC_W-1:0] OUT_MAX = ~OUT_MIN;
`endif

    // Sign-extend a lane product to accumulator width.
    function automatic logic signed [ACC_W-1:0] sext(input logic signed [PROD_W-1:0] p);
        sext = {{(ACC_W - PROD_W){p[PROD_W-1]}}, p};
    endfunction

    // Narrow an accumulator to the output width (saturating or wrapping).
    function automatic logic signed [OUT_W-1:0] narrow(input logic signed [ACC_W-1:0] v);
`ifdef MAC_STREAM_SAT_EN
        if (v > OUT_MAX) begin
            narrow = OUT_MAX[OUT_W-1:0];
        end else if (v < OUT_MIN) begin
            narrow = OUT_MIN[OUT_W-1:0];
        end else begin
            narrow = v[OUT_W-1:0];
        end
`else
        narrow = v[OUT_W-1:0];
`endif
    endfunction

    // Handshake / stall
    logic                       stall;
    logic                       accept;

    // Stage 1: products
    logic signed [PROD_W-1:0]   prod_c [LANES];
    logic signed [PROD_W-1:0]   prod_p1 [LANES];
    logic                       vld_p1;
    logic                       last_p1;

    // Stage 2: accumulators
    logic signed [ACC_W-1:0]    acc_p2 [LANES];
    logic [CNT_W-1:0]           cnt_p2;
    logic                       vld_p2;
    logic                       last_p2;
    logic                       open_p2;

    // Stage 2 next-term bookkeeping
    logic [CNT_W-1:0]           cnt_next;
    logic                       at_max;
    logic                       last_eff;
    logic                       overrun;

    // The pipe only freezes when a finished result cannot leave stage 2.
    assign stall    = out_valid && !out_ready && vld_p2 && last_p2;
    assign in_ready = !rst && !stall;
    assign accept   = in_valid && in_ready;

    // Per-lane signed products at full 2*DATA_W precision.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            prod_c[i] = PROD_W'($signed(a_in[i*DATA_W +: DATA_W]))
                      * PROD_W'($signed(b_in[i*DATA_W +: DATA_W]));
        end
    end

    // Term count of the incoming stage-2 term; the K_MAX-th term closes the vector.
    always_comb begin
        cnt_next = open_p2 ? cnt_p2 + CNT_W'(1) : CNT_W'(1);
        at_max   = (cnt_next == CNT_W'(K_MAX));
        last_eff = last_p1 || at_max;
        overrun  = at_max && !last_p1;
    end

    // ---- stage 1 boundary ----
    // Product registers carry data only and need no reset.
    always_ff @(posedge clk) begin
        if (!stall) begin
            for (int i = 0; i < LANES; i++) begin
                prod_p1[i] <= prod_c[i];
            end
        end
    end

    // Stage 1 control: valid and last travel with the products.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
        end else if (!stall) begin
            vld_p1  <= accept;
            last_p1 <= in_last;
        end
    end

    // ---- stage 2 boundary ----
    // Accumulate; the first term of a vector loads the product directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LANES; i++) begin
                acc_p2[i] <= '0;
            end
            cnt_p2   <= '0;
            vld_p2   <= 1'b0;
            last_p2  <= 1'b0;
            open_p2  <= 1'b0;
            term_err <= 1'b0;
        end else if (!stall) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                for (int i = 0; i < LANES; i++) begin
                    acc_p2[i] <= (open_p2 ? acc_p2[i] : '0) + sext(prod_p1[i]);
                end
                cnt_p2  <= cnt_next;
                last_p2 <= last_eff;
                open_p2 <= !last_eff;
                if (overrun) begin
                    term_err <= 1'b1;
                end
            end
        end
    end

    // ---- output register boundary ----
    // Load a finished vector (replacing a draining one), otherwise drain on out_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
        end else if (vld_p2 && last_p2 && !stall) begin
            out_valid <= 1'b1;
            for (int i = 0; i < LANES; i++) begin
                out_data[i*OUT_W +: OUT_W] <= narrow(acc_p2[i]);
            end
            out_count <= cnt_p2;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mac_stream.sv
// Directed testbench for mac_stream with default parameters
// (DATA_W=16, K_MAX=4, LANES=4, OUT_W=32). Lane 3 mirrors lane 0 stimulus,
// lane 2 is held at zero.
module tb_mac_stream;

    localparam int DATA_W = 16;
    localparam int K_MAX  = 4;
    localparam int LANES  = 4;
    localparam int OUT_W  = 32;
    localparam int CNT_W  = $clog2(K_MAX + 1);

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     in_valid;
    logic                     in_ready;
    logic                     in_last;
    logic [LANES*DATA_W-1:0]  a_in;
    logic [LANES*DATA_W-1:0]  b_in;
    logic                     out_valid;
    logic                     out_ready;
    logic [LANES*OUT_W-1:0]   out_data;
    logic [CNT_W-1:0]         out_count;
    logic                     term_err;

    int n_checks = 0;
    int n_errors = 0;

    mac_stream #(
        .DATA_W (DATA_W),
        .K_MAX  (K_MAX),
        .LANES  (LANES),
        .OUT_W  (OUT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .a_in      (a_in),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .term_err  (term_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lane(input int i);
        return out_data[i*OUT_W +: OUT_W];
    endfunction

    // Advance one clock; inputs and samples settle 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input int a0, input int b0, input int a1, input int b1,
                            input logic last);
        in_valid = 1'b1;
        in_last  = last;
        a_in     = '0;
        b_in     = '0;
        a_in[0*DATA_W +: DATA_W] = a0[DATA_W-1:0];
        b_in[0*DATA_W +: DATA_W] = b0[DATA_W-1:0];
        a_in[1*DATA_W +: DATA_W] = a1[DATA_W-1:0];
        b_in[1*DATA_W +: DATA_W] = b1[DATA_W-1:0];
        a_in[3*DATA_W +: DATA_W] = a0[DATA_W-1:0];
        b_in[3*DATA_W +: DATA_W] = b0[DATA_W-1:0];
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
        a_in     = '0;
        b_in     = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        out_ready = 1'b1;
        idle();

        // Reset state
        step();
        step();
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(|out_data), 32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        check("rst_term_err",  32'(term_err),  32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // 4-term vector: lane0 1..4 x 5..8 = 70, lane1 4 x (-2*3) = -24
        set_beat(1, 5, -2, 3, 1'b0); step();
        set_beat(2, 6, -2, 3, 1'b0); step();
        set_beat(3, 7, -2, 3, 1'b0); step();
        set_beat(4, 8, -2, 3, 1'b1); step();
        idle();
        check("dot_lat0", 32'(out_valid), 32'd0);
        step();
        check("dot_lat1", 32'(out_valid), 32'd0);
        step();
        check("dot_valid", 32'(out_valid), 32'd1);
        check("dot_lane0", lane(0), 32'd70);
        check("dot_lane1", lane(1), -32'sd24);
        check("dot_lane2", lane(2), 32'd0);
        check("dot_lane3", lane(3), 32'd70);
        check("dot_count", 32'(out_count), 32'd4);
        check("dot_term_err", 32'(term_err), 32'd0);
        step();
        check("dot_drained", 32'(out_valid), 32'd0);

        // Signed extremes: lane0 4 x 2^30 = 2^32, lane1 4 x (-1073709056)
        for (int k = 0; k < 4; k++) begin
            set_beat(-32768, -32768, 32767, -32768, 1'(k == 3));
            step();
        end
        idle();
        step();
        step();
        check("ext_valid", 32'(out_valid), 32'd1);
`ifdef MAC_STREAM_SAT_EN
        check("ext_lane0", lane(0), 32'h7FFF_FFFF);
        check("ext_lane1", lane(1), 32'h8000_0000);
`else
        check("ext_lane0", lane(0), 32'h0000_0000);
        check("ext_lane1", lane(1), 32'h0002_0000);
`endif
        check("ext_count", 32'(out_count), 32'd4);

        // Back-to-back single-term vectors
        for (int k = 0; k < 10; k++) begin
            if (k < 8) begin
                set_beat(k + 1, -(k + 2), k, 7, 1'b1);
                check($sformatf("b2b_in_ready%0d", k), 32'(in_ready), 32'd1);
            end else begin
                idle();
            end
            step();
            if (k >= 2) begin
                check($sformatf("b2b_valid%0d", k - 2), 32'(out_valid), 32'd1);
                check($sformatf("b2b_lane0_%0d", k - 2), lane(0), 32'((k - 1) * -k));
                check($sformatf("b2b_lane1_%0d", k - 2), lane(1), 32'((k - 2) * 7));
                check($sformatf("b2b_count%0d", k - 2), 32'(out_count), 32'd1);
            end
        end
        step();
        check("b2b_drained", 32'(out_valid), 32'd0);

        // Backpressure: A = 2*3+4*5 = 26, B = 1*1+1*2 = 3, C = 5*5 = 25
        out_ready = 1'b0;
        set_beat(2, 3, 0, 0, 1'b0); step();
        set_beat(4, 5, 0, 0, 1'b1); step();
        set_beat(1, 1, 0, 0, 1'b0); step();
        set_beat(1, 2, 0, 0, 1'b1); step();
        idle();
        check("bp_a_valid", 32'(out_valid), 32'd1);
        check("bp_a_lane0", lane(0), 32'd26);
        step();
        check("bp_stall_in_ready", 32'(in_ready), 32'd0);
        check("bp_hold_lane0", lane(0), 32'd26);
        check("bp_hold_count", 32'(out_count), 32'd2);
        set_beat(5, 5, 0, 0, 1'b1);
        step();
        check("bp_stall2_in_ready", 32'(in_ready), 32'd0);
        check("bp_hold2_lane0", lane(0), 32'd26);
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        step();
        idle();
        check("bp_b_valid", 32'(out_valid), 32'd1);
        check("bp_b_lane0", lane(0), 32'd3);
        check("bp_b_count", 32'(out_count), 32'd2);
        step();
        check("bp_gap", 32'(out_valid), 32'd0);
        step();
        check("bp_c_valid", 32'(out_valid), 32'd1);
        check("bp_c_lane0", lane(0), 32'd25);
        check("bp_c_count", 32'(out_count), 32'd1);
        step();

        // Overrun: terms 1..4 forced closed, term 5 opens a new vector closed by term 6
        for (int k = 1; k <= 6; k++) begin
            set_beat(k, 1, 0, 0, 1'(k == 6));
            step();
        end
        idle();
        check("ovr_valid", 32'(out_valid), 32'd1);
        check("ovr_lane0", lane(0), 32'd10);
        check("ovr_count", 32'(out_count), 32'd4);
        check("ovr_term_err", 32'(term_err), 32'd1);
        step();
        check("ovr_gap", 32'(out_valid), 32'd0);
        step();
        check("ovr2_lane0", lane(0), 32'd11);
        check("ovr2_count", 32'(out_count), 32'd2);
        check("ovr2_term_err", 32'(term_err), 32'd1);
        step();

        // Reset mid-vector
        set_beat(9, 9, 0, 0, 1'b0); step();
        set_beat(9, 9, 0, 0, 1'b0); step();
        idle();
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        step();
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_data",  32'(|out_data), 32'd0);
        check("mid_rst_out_count", 32'(out_count), 32'd0);
        check("mid_rst_term_err",  32'(term_err),  32'd0);
        step();
        rst = 1'b0;
        set_beat(3, 3, 0, 0, 1'b0); step();
        set_beat(3, 3, 0, 0, 1'b1); step();
        idle();
        step();
        step();
        check("fresh_valid", 32'(out_valid), 32'd1);
        check("fresh_lane0", lane(0), 32'd18);
        check("fresh_count", 32'(out_count), 32'd2);
        check("fresh_term_err", 32'(term_err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
